ieee754_mul_seq: RTL and testbench
==================================

IEEE754_MUL_SEQ -- requirements
Module: ieee754_mul_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to multiply a by b, sampled only in IDLE.
REQ-004 SHALL have ports a and b, inputs, 32 bits each: IEEE-754 single-precision operands, captured on the accepting edge.
REQ-005 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse marking a new result.
REQ-007 SHALL have port result, output, 32 bits: product, held until the next done.
REQ-008 SHALL have ports overflow and underflow, outputs, 1 bit each: flags valid with result and held with it.

Function
REQ-009 SHALL implement FSM states IDLE, MUL, NORM and DONE.
REQ-010 SHALL move IDLE->MUL on an edge with start=1 and finite non-zero operands, capturing the sign, both exponents and both 24-bit mantissas (hidden 1 prepended).
REQ-011 SHALL stay in MUL for exactly 24 cycles, adding one multiplier bit per cycle (shift-add) into a 48-bit product, with a 5-bit iteration counter running 0..23.
REQ-012 SHALL move MUL->NORM after iteration 23 and NORM->DONE on the next edge, registering result and flags on the NORM->DONE edge.
REQ-013 SHALL hold DONE for one cycle with done=1, then return to IDLE.
REQ-014 SHALL give finite-operand latency as: start edge N -> done high in the cycle following edge N+25.
REQ-015 SHALL compute the exponent as ea+eb-127 in 10-bit signed arithmetic, plus 1 when product bit 47 is set.
REQ-016 SHALL take the fraction from product[46:24] when bit 47 is set, else from product[45:23].
REQ-017 SHALL truncate with no rounding.
REQ-018 SHALL give the result sign as sa XOR sb in all cases, including zero and infinity; NaN is fixed positive per REQ-022.
REQ-019 SHALL, when the final exponent >= 255, produce signed infinity (exponent 0xFF, fraction 0) with overflow=1.
REQ-020 SHALL, when the final exponent <= 0, produce signed zero with underflow=1; no denormal outputs are produced.
REQ-021 SHALL treat operands with exponent 0 as zero (denormals flushed).
REQ-022 SHALL short-circuit special operands IDLE->DONE on the start edge, done one cycle later, both flags 0: NaN on either side or inf*0 -> 0x7FC00000; inf times finite/inf -> signed infinity; zero times finite -> signed zero.
REQ-023 SHALL ignore start while busy=1; operands are not re-sampled.
REQ-024 SHALL, when start=1 is sampled in the same cycle DONE returns to IDLE, not accept it; start is accepted from IDLE only, one cycle later.

Reset
REQ-025 SHALL force state=IDLE, counter=0, product=0, busy=0, done=0, result=0x00000000, overflow=0 and underflow=0 while rst=1, independent of clk.
REQ-026 SHALL, on reset asserted mid-operation, abandon the operation and produce no done; the first start after release begins a fresh operation.

Structure
REQ-027 SHALL place the FSM state enum, EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000 and MANT_W=24 in shared package ieee754_pkg, which ieee754_divider also uses.
REQ-028 SHALL implement operand classification (is_nan, is_inf, is_zero per operand) in combinational sub-module ieee754_classify, instantiated twice.

Verification
REQ-029 SHALL cover: a=0x40000000 (2.0), b=0x40400000 (3.0), start at edge N -> result=0x40C00000, flags 0, done only in the cycle after N+25, busy high for 26 cycles.
REQ-030 SHALL cover: a=b=0x3FC00000 (1.5) -> 0x40100000 (bit-47 normalization); a=0xC0000000, b=0x40400000 -> 0xC0C00000.
REQ-031 SHALL cover: a=0x7F800000, b=0x00000000 -> 0x7FC00000 with done one cycle after start; a=0x7F800000, b=0xBF800000 -> 0xFF800000.
REQ-032 SHALL cover: a=b=0x7F000000 -> 0x7F800000 with overflow=1; a=b=0x00800000 -> 0x00000000 with underflow=1.
REQ-033 SHALL cover: start pulsed with new operands at cycle 10 of MUL -> ignored, original product delivered; rst asserted at cycle 12 of MUL -> all outputs 0 immediately, no done, next start yields a correct 26-cycle result.

Source files
------------

// File: rtl/ieee754_pkg.sv
// rtl/ieee754_pkg.sv - shared single-precision constants and FSM encoding
package ieee754_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int MANT_W   = 24;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_NORM = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    function automatic logic [31:0] signed_inf(input logic s);
        return {s, 8'hFF, 23'd0};
    endfunction

endpackage

// File: rtl/ieee754_mul_seq_if.sv
// rtl/ieee754_mul_seq_if.sv - request/result bundle of the sequential multiplier
interface ieee754_mul_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    modport master (output start, a, b,
                    input  busy, done, result, overflow, underflow);
    modport slave  (input  start, a, b,
                    output busy, done, result, overflow, underflow);
endinterface

// File: rtl/ieee754_classify.sv
// rtl/ieee754_classify.sv - combinational NaN/inf/zero classification of one operand
module ieee754_classify
    import ieee754_pkg::*;
(
    input  logic [31:0] x,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero
);
    logic exp_max;

    assign exp_max = (x[30:23] == 8'(EXP_MAX));
    assign is_nan  = exp_max && (x[22:0] != 23'd0);
    assign is_inf  = exp_max && (x[22:0] == 23'd0);
    // Denormals are flushed, so any zero exponent counts as zero.
    assign is_zero = (x[30:23] == 8'd0);
endmodule

// File: rtl/ieee754_mul_seq.sv
// rtl/ieee754_mul_seq.sv - shift-add single-precision multiplier, truncating, 26-cycle latency
module ieee754_mul_seq
    import ieee754_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ieee754_mul_seq_if.slave  bus
);
    state_t              state;
    logic [4:0]          cnt;
    logic [2*MANT_W-1:0] prod;
    logic [2*MANT_W-1:0] mcand;
    logic [MANT_W-1:0]   mplier;
    logic                sign;
    logic [7:0]          ea;
    logic [7:0]          eb;
    logic [31:0]         result_q;
    logic                ovf_q;
    logic                udf_q;

    logic nan_a, inf_a, zero_a, nan_b, inf_b, zero_b;

    ieee754_classify u_cls_a (.x(bus.a), .is_nan(nan_a), .is_inf(inf_a), .is_zero(zero_a));
    ieee754_classify u_cls_b (.x(bus.b), .is_nan(nan_b), .is_inf(inf_b), .is_zero(zero_b));

    logic        in_sign;
    logic        is_special;
    logic [31:0] spec_res;

    assign in_sign    = bus.a[31] ^ bus.b[31];
    assign is_special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;

    always_comb begin
        spec_res = {in_sign, 31'd0};
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
            spec_res = QNAN;
        else if (inf_a || inf_b)
            spec_res = signed_inf(in_sign);
    end

    logic signed [9:0] exp_s;
    logic [22:0]       frac;
    logic [31:0]       norm_res;
    logic              norm_ovf;
    logic              norm_udf;

    always_comb begin
        exp_s = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(10'(EXP_BIAS))
              + $signed({9'd0, prod[47]});
        frac     = prod[47] ? prod[46:24] : prod[45:23];
        norm_res = {sign, exp_s[7:0], frac};
        norm_ovf = 1'b0;
        norm_udf = 1'b0;
        if (exp_s >= $signed(10'(EXP_MAX))) begin
            norm_res = signed_inf(sign);
            norm_ovf = 1'b1;
        end else if (exp_s <= 10'sd0) begin
            norm_res = {sign, 31'd0};
            norm_udf = 1'b1;
        end
    end

    // Low product bits fall away under truncation.
    logic unused_low_bits;
    assign unused_low_bits = ^prod[22:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 5'd0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            sign     <= 1'b0;
            ea       <= 8'd0;
            eb       <= 8'd0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (is_special) begin
                            result_q <= spec_res;
                            ovf_q    <= 1'b0;
                            udf_q    <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            sign   <= in_sign;
                            ea     <= bus.a[30:23];
                            eb     <= bus.b[30:23];
                            mcand  <= {{MANT_W{1'b0}}, 1'b1, bus.a[22:0]};
                            mplier <= {1'b1, bus.b[22:0]};
                            prod   <= '0;
                            cnt    <= 5'd0;
                            state  <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    // One multiplier bit per cycle, LSB first.
                    if (mplier[0])
                        prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == 5'(MANT_W - 1)) begin
                        cnt   <= 5'd0;
                        state <= ST_NORM;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_NORM: begin
                    result_q <= norm_res;
                    ovf_q    <= norm_ovf;
                    udf_q    <= norm_udf;
                    state    <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule

// File: tb/tb_ieee754_mul_seq.sv
// tb/tb_ieee754_mul_seq.sv - directed and random checks of ieee754_mul_seq against an arithmetic model
module tb_ieee754_mul_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ieee754_mul_seq_if bus ();

    ieee754_mul_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {special, result, overflow, underflow}
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e;
        logic        nx, ny, ix, iy, zx, zy;
        logic [47:0] p;
        logic [22:0] f;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny || (ix && zy) || (iy && zx)) return {1'b1, 32'h7FC00000, 2'b00};
        if (ix || iy) return {1'b1, s, 8'hFF, 23'd0, 2'b00};
        if (zx || zy) return {1'b1, s, 31'd0, 2'b00};
        p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e = ex + ey - 127;
        if (p[47]) begin
            e = e + 1;
            f = p[46:24];
        end else begin
            f = p[45:23];
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0, 2'b10};
        if (e <= 0)   return {1'b0, s, 31'd0, 2'b01};
        return {1'b0, s, e[7:0], f, 2'b00};
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or linger one more cycle).
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input int poke, input bit linger);
        logic [34:0] m;
        int  cyc, busy_n;
        bit  got;
        m = model(x, y);
        bus.start = 1'b1;
        bus.a = x;
        bus.b = y;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        busy_n = 0;
        got = 1'b0;
        while (cyc < 40) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (cyc == poke) begin
                bus.start = 1'b1;
                bus.a = $urandom;
                bus.b = $urandom;
            end else if (cyc == poke + 1) begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(cyc), m[34] ? 32'd0 : 32'd25);
        chk({tag, " busy_cycles"}, 32'(busy_n), m[34] ? 32'd1 : 32'd26);
        chk({tag, " result"}, bus.result, m[33:2]);
        chk({tag, " flags"}, {30'd0, bus.overflow, bus.underflow}, {30'd0, m[1:0]});
        if (linger) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, " done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
            chk({tag, " result_held"}, bus.result, m[33:2]);
        end
    endtask

    initial begin
        int nd;
        logic [31:0] x, y;
        bus.start = 1'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        #1;
        chk("reset_outputs", {28'd0, bus.busy, bus.done, bus.overflow, bus.underflow}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("two_times_three", 32'h40000000, 32'h40400000, -1, 1'b1);
        chk("two_times_three const", bus.result, 32'h40C00000);
        run_op("one_five_sq", 32'h3FC00000, 32'h3FC00000, -1, 1'b1);
        chk("one_five_sq const", bus.result, 32'h40100000);
        run_op("neg_two_times_three", 32'hC0000000, 32'h40400000, -1, 1'b1);
        chk("neg_two_times_three const", bus.result, 32'hC0C00000);
        run_op("inf_times_zero", 32'h7F800000, 32'h00000000, -1, 1'b1);
        chk("inf_times_zero const", bus.result, 32'h7FC00000);
        run_op("inf_times_neg_one", 32'h7F800000, 32'hBF800000, -1, 1'b1);
        chk("inf_times_neg_one const", bus.result, 32'hFF800000);
        run_op("overflow", 32'h7F000000, 32'h7F000000, -1, 1'b1);
        chk("overflow const", {bus.result[30:0], bus.overflow}, {31'h7F800000, 1'b1});
        run_op("underflow", 32'h00800000, 32'h00800000, -1, 1'b1);
        chk("underflow const", {bus.result[30:0], bus.underflow}, {31'd0, 1'b1});
        run_op("nan_in", 32'h7FC12345, 32'h3F800000, -1, 1'b1);
        run_op("neg_zero", 32'h80000000, 32'h40000000, -1, 1'b1);

        run_op("start_ignored_busy", 32'h40000000, 32'h40400000, 10, 1'b1);

        // start held through the DONE cycle is not taken until IDLE.
        run_op("done_then_start", 32'h3FC00000, 32'h40000000, -1, 1'b0);
        bus.start = 1'b1;
        bus.a = 32'h40400000;
        bus.b = 32'h40400000;
        @(negedge clk);
        chk("start_in_done_ignored", 32'(bus.busy), 32'd0);
        run_op("start_after_done", 32'h40400000, 32'h40400000, -1, 1'b1);

        // Reset in the middle of MUL.
        bus.start = 1'b1;
        bus.a = 32'h40000000;
        bus.b = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midop_reset_outputs", {28'd0, bus.busy, bus.done, bus.overflow, bus.underflow}, 32'd0);
        chk("midop_reset_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        chk("no_done_after_reset", 32'(nd), 32'd0);
        run_op("after_reset", 32'h40000000, 32'h40400000, -1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_op("random_raw", $urandom, $urandom, -1, 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            x = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            y = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            run_op("random_normal", x, y, -1, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            x = {1'($urandom), 8'($urandom_range(1, 40)), 23'($urandom)};
            y = {1'($urandom), 8'($urandom_range(200, 254)), 23'($urandom)};
            run_op("random_edge", (i % 2 == 0) ? x : y, (i % 3 == 0) ? x : y, -1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
